calc_sequencer: RTL and testbench

Accumulator-style controller for the shared 4-bit signed calculator datapath. It accepts commands over a valid/ready handshake and drives the datapath's operand and op-select inputs. It waits a programmable settle time, then captures the result into a 4-bit two's-complement accumulator. Datapath overflow halts the sequencer behind a sticky error until software clears it. The block sits between the board-level command source (keys/switches or a host) and the existing combinational calculator.

---
 rtl/calc_sequencer.sv | 153 +++++++++++++++
 tb/tb_calc_sequencer.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: accumulator-style command sequencer for the shared 4-bit
// signed calculator datapath. Loads go straight into the accumulator. Ops are
// presented to the datapath for ALU_WAIT cycles and then captured. A datapath
// overflow parks the block in HALT behind a sticky error until clear_err.
//
// Handshake: a command transfers on a rising CLOCK_50 edge where
// cmd_valid & cmd_ready are both 1. cmd_ready is high only in IDLE.
// cmd_load/cmd_op/cmd_operand are sampled only at that edge. The source may
// change them freely afterwards. The source may raise cmd_valid while
// cmd_ready is low. The command then waits, and nothing transfers until
// cmd_ready rises.
module calc_sequencer #(
   parameter int unsigned ALU_WAIT = 1   // settle cycles, legal 1..15
) (
   input  logic       CLOCK_50,
   input  logic       RESET_N,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_load,
   input  logic [2:0] cmd_op,
   input  logic [3:0] cmd_operand,
   input  logic       clear_err,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_op,
   input  logic [3:0] alu_r,
   input  logic       alu_ovf,
   output logic [3:0] acc,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] op_count,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_HALT  = 2'd2
   } state_e;

   // Counter preload. The capture happens on the edge where the counter
   // is already zero, so ALU_WAIT-1 gives exactly ALU_WAIT DRIVE cycles.
   localparam logic [3:0] WAIT_INIT = 4'(ALU_WAIT - 1);

   state_e     state_q, state_d;
   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic [3:0] acc_q, acc_d;
   logic [3:0] alu_a_q, alu_a_d;
   logic [3:0] alu_b_q, alu_b_d;
   logic [2:0] alu_op_q, alu_op_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic [7:0] op_count_q, op_count_d;
   logic       accept;

   assign accept = cmd_valid && (state_q == ST_IDLE);

   // Next-state and datapath register updates for the IDLE/DRIVE/HALT sequencer
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      acc_d      = acc_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      done_d     = 1'b0;
      err_d      = err_q;
      op_count_d = op_count_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (cmd_load) begin
                  // Loads complete in the accept cycle and stay in IDLE
                  acc_d      = cmd_operand;
                  op_count_d = op_count_q + 8'd1;
                  done_d     = 1'b1;
               end else begin
                  alu_a_d    = acc_q;
                  alu_b_d    = cmd_operand;
                  alu_op_d   = cmd_op;
                  wait_cnt_d = WAIT_INIT;
                  state_d    = ST_DRIVE;
               end
            end
         end

         ST_DRIVE: begin
            if (wait_cnt_q != 4'd0) begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end else if (!alu_ovf) begin
               acc_d      = alu_r;
               op_count_d = op_count_q + 8'd1;
               done_d     = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               // Faulting command stays visible on alu_* while halted
               err_d   = 1'b1;
               state_d = ST_HALT;
            end
         end

         ST_HALT: begin
            if (clear_err) begin
               err_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and register bank, asynchronously cleared by RESET_N
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= 4'd0;
         acc_q      <= 4'd0;
         alu_a_q    <= 4'd0;
         alu_b_q    <= 4'd0;
         alu_op_q   <= 3'd0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         op_count_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         acc_q      <= acc_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         done_q     <= done_d;
         err_q      <= err_d;
         op_count_q <= op_count_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_DRIVE);
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_op    = alu_op_q;
   assign acc       = acc_q;
   assign done      = done_q;
   assign err       = err_q;
   assign op_count  = op_count_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer. The main instance runs with ALU_WAIT=1 and
// drives a behavioural calculator. A second instance runs with ALU_WAIT=4
// and has its datapath result driven by hand.
module tb_calc_sequencer;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------- main instance (ALU_WAIT = 1) ----------------
   logic       rst_n;
   logic       cmd_valid, cmd_load, clear_err;
   logic [2:0] cmd_op;
   logic [3:0] cmd_operand;
   logic       cmd_ready;
   logic [3:0] alu_a, alu_b, alu_r, acc;
   logic [2:0] alu_op;
   logic       alu_ovf, busy, done, err;
   logic [7:0] op_count;
   logic [1:0] state_dbg;

   calc_sequencer #(.ALU_WAIT(1)) dut (
      .CLOCK_50(clk), .RESET_N(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
      .cmd_op(cmd_op), .cmd_operand(cmd_operand), .clear_err(clear_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_r(alu_r), .alu_ovf(alu_ovf),
      .acc(acc), .busy(busy), .done(done), .err(err),
      .op_count(op_count), .state_dbg(state_dbg)
   );

   // ---------------- long-wait instance (ALU_WAIT = 4) ----------------
   logic       w_rst_n;
   logic       w_cmd_valid, w_cmd_load, w_clear_err;
   logic [2:0] w_cmd_op;
   logic [3:0] w_cmd_operand;
   logic       w_cmd_ready;
   logic [3:0] w_alu_a, w_alu_b, w_alu_r, w_acc;
   logic [2:0] w_alu_op;
   logic       w_alu_ovf, w_busy, w_done, w_err;
   logic [7:0] w_op_count;
   logic [1:0] w_state_dbg;

   calc_sequencer #(.ALU_WAIT(4)) dut_w (
      .CLOCK_50(clk), .RESET_N(w_rst_n),
      .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready), .cmd_load(w_cmd_load),
      .cmd_op(w_cmd_op), .cmd_operand(w_cmd_operand), .clear_err(w_clear_err),
      .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_op(w_alu_op),
      .alu_r(w_alu_r), .alu_ovf(w_alu_ovf),
      .acc(w_acc), .busy(w_busy), .done(w_done), .err(w_err),
      .op_count(w_op_count), .state_dbg(w_state_dbg)
   );

   // Behavioural calculator: exact integer result of the selected op
   function automatic int calc_int(input logic [3:0] a, input logic [3:0] b,
                                   input logic [2:0] op);
      int sa;
      int sb;
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         3'b000, 3'b100: return sa + sb;
         3'b001:         return sa - sb;
         3'b101:         return sb - sa;
         3'b010, 3'b011: return (sb < 0) ? -sb : sb;
         default:        return (sa < 0) ? -sa : sa;
      endcase
   endfunction

   int calc_val;
   // Datapath model feeding the main instance
   always_comb begin
      calc_val = calc_int(alu_a, alu_b, alu_op);
      alu_r    = calc_val[3:0];
      alu_ovf  = (calc_val > 7) || (calc_val < -8);
   end

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic reset_main();
      cmd_valid   = 1'b0;
      cmd_load    = 1'b0;
      cmd_op      = 3'd0;
      cmd_operand = 4'd0;
      clear_err   = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Presents one command; returns at the negedge just after the accept edge
   task automatic send_cmd(input logic ld, input logic [2:0] op, input logic [3:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 32'(n < 50), 1);
      cmd_valid   = 1'b1;
      cmd_load    = ld;
      cmd_op      = op;
      cmd_operand = b;
      @(negedge clk);
      cmd_valid   = 1'b0;
      cmd_load    = 1'($urandom_range(0, 1));
      cmd_op      = 3'($urandom_range(0, 7));
      cmd_operand = 4'($urandom_range(0, 15));
   endtask

   // Waits (bounded) for the command to end in done or err
   task automatic wait_result(output logic got_done, output logic got_err);
      int n;
      n = 0;
      got_done = 1'b0;
      got_err  = 1'b0;
      while (n < 50) begin
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (err) begin
            got_err = 1'b1;
            break;
         end
         @(negedge clk);
         n++;
      end
      check("result_wait", 32'(got_done || got_err), 1);
   endtask

   task automatic pulse_clear();
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      check("clear_err_low", 32'(err), 0);
      check("clear_ready", 32'(cmd_ready), 1);
   endtask

   typedef struct {
      logic       ld;
      logic [2:0] op;
      logic [3:0] b;
      logic [3:0] exp_acc;
      logic       exp_err;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t       tbl[12];
   logic [3:0] exp_q[$];

   // Global watchdog
   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       gd, ge;
      logic [1:0] idle_code;
      logic [1:0] w_idle_code;
      logic [3:0] last_b;
      logic [3:0] m_acc;
      logic [7:0] m_cnt;
      logic       m_err;
      logic       ld;
      logic [2:0] op;
      logic [3:0] b;
      int         r;

      rst_n         = 1'b1;
      w_rst_n       = 1'b0;
      w_cmd_valid   = 1'b0;
      w_cmd_load    = 1'b0;
      w_cmd_op      = 3'd0;
      w_cmd_operand = 4'd0;
      w_clear_err   = 1'b0;
      w_alu_r       = 4'd0;
      w_alu_ovf     = 1'b0;
      cmd_valid     = 1'b0;
      cmd_load      = 1'b0;
      cmd_op        = 3'd0;
      cmd_operand   = 4'd0;
      clear_err     = 1'b0;

      // ---- reset values ----
      #3 rst_n = 1'b0;
      #1;
      check("rst_acc", 32'(acc), 0);
      check("rst_alu_a", 32'(alu_a), 0);
      check("rst_alu_b", 32'(alu_b), 0);
      check("rst_alu_op", 32'(alu_op), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_op_count", 32'(op_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", 32'(cmd_ready), 1);
      idle_code = state_dbg;

      // ---- load 3: done one cycle, ready stays high ----
      send_cmd(1'b1, 3'b000, 4'd3);
      check("load3_acc", 32'(acc), 4'b0011);
      check("load3_done", 32'(done), 1);
      check("load3_cnt", 32'(op_count), 1);
      check("load3_ready", 32'(cmd_ready), 1);
      @(negedge clk);
      check("load3_done_gone", 32'(done), 0);

      // ---- op timing with ALU_WAIT = 1 ----
      reset_main();
      send_cmd(1'b1, 3'b000, 4'd4);
      send_cmd(1'b0, 3'b000, 4'd3);
      check("op_alu_a", 32'(alu_a), 4'b0100);
      check("op_alu_b", 32'(alu_b), 4'b0011);
      check("op_alu_op", 32'(alu_op), 3'b000);
      check("op_busy", 32'(busy), 1);
      check("op_ready_low", 32'(cmd_ready), 0);
      check("op_no_early_done", 32'(done), 0);
      @(negedge clk);
      check("op_acc", 32'(acc), 4'b0111);
      check("op_done", 32'(done), 1);
      check("op_busy_low", 32'(busy), 0);
      check("op_ready_back", 32'(cmd_ready), 1);
      check("op_cnt", 32'(op_count), 2);

      // ---- overflow -> HALT, blocked command, clear vs valid ----
      reset_main();
      send_cmd(1'b1, 3'b000, 4'd7);
      send_cmd(1'b0, 3'b000, 4'd1);
      @(negedge clk);
      check("ovf_err", 32'(err), 1);
      check("ovf_no_done", 32'(done), 0);
      check("ovf_ready", 32'(cmd_ready), 0);
      check("ovf_acc", 32'(acc), 4'b0111);
      check("ovf_cnt", 32'(op_count), 1);
      check("ovf_hold_a", 32'(alu_a), 4'b0111);
      check("ovf_hold_b", 32'(alu_b), 4'b0001);
      check("ovf_state_not_idle", 32'(state_dbg != idle_code), 1);
      cmd_valid   = 1'b1;
      cmd_load    = 1'b1;
      cmd_operand = 4'd5;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("halt_blocks_cmd", 32'(acc), 4'b0111);
         check("halt_no_done", 32'(done), 0);
         check("halt_err_sticky", 32'(err), 1);
      end
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      check("clear_wins_acc", 32'(acc), 4'b0111);
      check("clear_wins_err", 32'(err), 0);
      check("clear_wins_ready", 32'(cmd_ready), 1);
      check("clear_wins_done", 32'(done), 0);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("after_clear_acc", 32'(acc), 4'd5);
      check("after_clear_done", 32'(done), 1);
      check("after_clear_cnt", 32'(op_count), 2);

      // ---- clear_err outside HALT is ignored ----
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      check("idle_clear_cnt", 32'(op_count), 2);
      check("idle_clear_acc", 32'(acc), 4'd5);
      check("idle_clear_done", 32'(done), 0);
      check("idle_clear_ready", 32'(cmd_ready), 1);

      // ---- reset mid-DRIVE ----
      send_cmd(1'b0, 3'b000, 4'd2);
      check("mid_busy", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_acc", 32'(acc), 0);
      check("mid_rst_alu_b", 32'(alu_b), 0);
      check("mid_rst_alu_a", 32'(alu_a), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_cnt", 32'(op_count), 0);
      check("mid_rst_ready", 32'(cmd_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("mid_rst_no_done", 32'(done), 0);
         check("mid_rst_no_capture", 32'(acc), 0);
      end

      // ---- table-driven command sequence ----
      tbl[0]  = '{1'b1, 3'b000, 4'd4,     4'd4,     1'b0, 8'd1};
      tbl[1]  = '{1'b0, 3'b000, 4'd3,     4'd7,     1'b0, 8'd2};
      tbl[2]  = '{1'b0, 3'b000, 4'd1,     4'd7,     1'b1, 8'd2};
      tbl[3]  = '{1'b1, 3'b000, 4'b1001,  4'b1001,  1'b0, 8'd3};
      tbl[4]  = '{1'b0, 3'b101, 4'b0111,  4'b1001,  1'b1, 8'd3};
      tbl[5]  = '{1'b1, 3'b000, 4'b1101,  4'b1101,  1'b0, 8'd4};
      tbl[6]  = '{1'b0, 3'b110, 4'd0,     4'b0011,  1'b0, 8'd5};
      tbl[7]  = '{1'b0, 3'b001, 4'd5,     4'b1110,  1'b0, 8'd6};
      tbl[8]  = '{1'b0, 3'b011, 4'b1000,  4'b1110,  1'b1, 8'd6};
      tbl[9]  = '{1'b0, 3'b100, 4'd2,     4'b0000,  1'b0, 8'd7};
      tbl[10] = '{1'b1, 3'b000, 4'b1000,  4'b1000,  1'b0, 8'd8};
      tbl[11] = '{1'b0, 3'b010, 4'b1011,  4'b0101,  1'b0, 8'd9};
      reset_main();
      for (int i = 0; i < 12; i++) begin
         send_cmd(tbl[i].ld, tbl[i].op, tbl[i].b);
         wait_result(gd, ge);
         check($sformatf("tbl%0d_err", i), 32'(ge), 32'(tbl[i].exp_err));
         check($sformatf("tbl%0d_acc", i), 32'(acc), 32'(tbl[i].exp_acc));
         check($sformatf("tbl%0d_cnt", i), 32'(op_count), 32'(tbl[i].exp_cnt));
         if (ge) pulse_clear();
      end

      // ---- ALU_WAIT = 4 instance: capture only at E+4 ----
      @(negedge clk);
      w_rst_n = 1'b1;
      @(negedge clk);
      w_idle_code   = w_state_dbg;
      w_cmd_valid   = 1'b1;
      w_cmd_load    = 1'b1;
      w_cmd_operand = 4'd1;
      @(negedge clk);
      w_cmd_valid = 1'b0;
      check("w_load_acc", 32'(w_acc), 1);
      w_alu_r   = 4'd6;
      w_alu_ovf = 1'b1;
      w_cmd_valid   = 1'b1;
      w_cmd_load    = 1'b0;
      w_cmd_op      = 3'b001;
      w_cmd_operand = 4'd2;
      @(negedge clk);
      w_cmd_valid = 1'b0;
      check("w_alu_a", 32'(w_alu_a), 1);
      check("w_alu_b", 32'(w_alu_b), 2);
      check("w_alu_op", 32'(w_alu_op), 3'b001);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("w_busy_%0d", k), 32'(w_busy), 1);
         check($sformatf("w_no_done_%0d", k), 32'(w_done), 0);
         check($sformatf("w_acc_hold_%0d", k), 32'(w_acc), 1);
         check($sformatf("w_no_err_%0d", k), 32'(w_err), 0);
         check($sformatf("w_state_%0d", k), 32'(w_state_dbg != w_idle_code), 1);
         if (k == 2) begin
            w_alu_r   = 4'd3;
            w_alu_ovf = 1'b0;
         end
         @(negedge clk);
      end
      check("w_busy_end", 32'(w_busy), 0);
      check("w_done", 32'(w_done), 1);
      check("w_acc", 32'(w_acc), 3);
      check("w_err", 32'(w_err), 0);
      check("w_ready", 32'(w_cmd_ready), 1);
      check("w_cnt", 32'(w_op_count), 2);

      // ---- 256 back-to-back loads: op_count wraps ----
      reset_main();
      cmd_valid = 1'b1;
      cmd_load  = 1'b1;
      last_b    = 4'd0;
      for (int i = 0; i < 256; i++) begin
         cmd_operand = 4'($urandom_range(0, 15));
         last_b      = cmd_operand;
         @(negedge clk);
         if (i == 254) check("wrap_255", 32'(op_count), 255);
      end
      cmd_valid = 1'b0;
      check("wrap_0", 32'(op_count), 0);
      check("wrap_acc", 32'(acc), 32'(last_b));
      check("wrap_done", 32'(done), 1);

      // ---- randomized commands against a reference model ----
      reset_main();
      m_acc = 4'd0;
      m_cnt = 8'd0;
      for (int i = 0; i < 150; i++) begin
         ld = ($urandom_range(0, 3) == 0);
         op = 3'($urandom_range(0, 7));
         b  = 4'($urandom_range(0, 15));
         if (ld) begin
            m_acc = b;
            m_cnt = m_cnt + 8'd1;
            m_err = 1'b0;
         end else begin
            r = calc_int(m_acc, b, op);
            if (r > 7 || r < -8) begin
               m_err = 1'b1;
            end else begin
               m_acc = r[3:0];
               m_cnt = m_cnt + 8'd1;
               m_err = 1'b0;
            end
         end
         exp_q.push_back(m_acc);
         send_cmd(ld, op, b);
         wait_result(gd, ge);
         check($sformatf("rnd%0d_err", i), 32'(ge), 32'(m_err));
         check($sformatf("rnd%0d_acc", i), 32'(acc), 32'(exp_q.pop_front()));
         check($sformatf("rnd%0d_cnt", i), 32'(op_count), 32'(m_cnt));
         if (ge) pulse_clear();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
